// File: rtl/squeeze_serializer.sv
// Squeeze-side output stage: unloads rate blocks of Keccak state as W-bit words,
// tracks the remaining output length and requests permutations between blocks.
module squeeze_serializer #(
    parameter int RATE_BITS = 1088,
    parameter int W         = 64,
    parameter int LEN_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     out_len_bits,
    input  logic [RATE_BITS-1:0]     state_in,
    input  logic                     state_valid,
    output logic                     state_ready,
    output logic                     perm_req,
    output logic [W-1:0]             dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     dout_last,
    output logic [$clog2(W+1)-1:0]   dout_nbits,
    output logic                     busy,
    output logic                     done
);

    localparam int WORDS = RATE_BITS / W;
    localparam int NBW   = $clog2(W + 1);
    localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;

    generate
        if (RATE_BITS % W != 0) begin : g_rate_check
            $error("squeeze_serializer: RATE_BITS must be a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WAIT_BLOCK, EMIT} state_t;

    state_t                 state;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [IDXW-1:0]        word_idx;
    logic [RATE_BITS-1:0]   shreg;

    logic [LEN_WIDTH-1:0]   rem_next;
    logic [RATE_BITS-1:0]   shreg_next;
    logic [NBW-1:0]         nb_next;
    logic                   hs;

    function automatic logic [NBW-1:0] word_bits(input logic [LEN_WIDTH-1:0] rem);
        if (rem >= LEN_WIDTH'(W))
            return NBW'(W);
        else
            return NBW'(rem);
    endfunction

    // Bits above the valid count of the final word are driven to zero.
    function automatic logic [W-1:0] mask_word(input logic [W-1:0] w, input logic [NBW-1:0] nb);
        logic [W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < W; i++)
            m[i] = (i < 32'(nb));
        return w & m;
    endfunction

    always_comb begin
        hs         = dout_valid && dout_ready;
        rem_next   = remaining - LEN_WIDTH'(dout_nbits);
        shreg_next = shreg >> W;
        nb_next    = word_bits(rem_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            word_idx    <= '0;
            shreg       <= '0;
            state_ready <= 1'b0;
            perm_req    <= 1'b0;
            dout        <= '0;
            dout_valid  <= 1'b0;
            dout_last   <= 1'b0;
            dout_nbits  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            perm_req <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (out_len_bits != '0) begin
                            remaining   <= out_len_bits;
                            state       <= WAIT_BLOCK;
                            state_ready <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                WAIT_BLOCK: begin
                    if (state_valid) begin
                        shreg       <= state_in;
                        word_idx    <= '0;
                        state       <= EMIT;
                        state_ready <= 1'b0;
                        dout_valid  <= 1'b1;
                        dout_nbits  <= word_bits(remaining);
                        dout_last   <= (remaining <= LEN_WIDTH'(W));
                        dout        <= mask_word(state_in[W-1:0], word_bits(remaining));
                    end
                end
                EMIT: begin
                    if (hs) begin
                        remaining <= rem_next;
                        shreg     <= shreg_next;
                        word_idx  <= word_idx + IDXW'(1);
                        // Final word takes priority over a simultaneous block boundary.
                        if (dout_last) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            dout_valid <= 1'b0;
                            dout       <= '0;
                            dout_last  <= 1'b0;
                            dout_nbits <= '0;
                        end else if (word_idx == IDXW'(WORDS - 1)) begin
                            state       <= WAIT_BLOCK;
                            state_ready <= 1'b1;
                            perm_req    <= 1'b1;
                            dout_valid  <= 1'b0;
                            dout        <= '0;
                            dout_last   <= 1'b0;
                            dout_nbits  <= '0;
                        end else begin
                            dout       <= mask_word(shreg_next[W-1:0], nb_next);
                            dout_nbits <= nb_next;
                            dout_last  <= (rem_next <= LEN_WIDTH'(W));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_squeeze_serializer.sv
// Scoreboard bench for squeeze_serializer: directed requests push expected words,
// an independent monitor pops and compares each accepted output word.
module tb_squeeze_serializer;

    localparam int W   = 64;
    localparam int R   = 1088;
    localparam int LW  = 32;
    localparam int NW  = R / W;
    localparam int NBW = $clog2(W + 1);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LW-1:0]     out_len_bits;
    logic [R-1:0]      state_in;
    logic              state_valid;
    logic              state_ready;
    logic              perm_req;
    logic [W-1:0]      dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic [NBW-1:0]    dout_nbits;
    logic              busy;
    logic              done;

    squeeze_serializer #(.RATE_BITS(R), .W(W), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .out_len_bits(out_len_bits),
        .state_in(state_in), .state_valid(state_valid), .state_ready(state_ready),
        .perm_req(perm_req), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last), .dout_nbits(dout_nbits),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   data;
        logic           last;
        logic [NBW-1:0] nbits;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   perm_cnt = 0;
    int   ready_mode = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [R-1:0] make_block(input int seed);
        logic [R-1:0] b;
        for (int i = 0; i < NW; i++)
            b[i*W +: W] = {32'(seed * 1000 + i + 1), 32'hC0DE_0000 ^ 32'(i * 7919 + seed)};
        return b;
    endfunction

    // Downstream ready: 0 = always, 1 = random stalls, 2 = never
    initial begin
        dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       dout_ready = 1'b1;
                1:       dout_ready = 1'($urandom_range(0, 1));
                default: dout_ready = 1'b0;
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, done/perm_req accounting
    initial begin
        logic           held;
        logic           exp_done_next;
        logic [W-1:0]   h_dout;
        logic           h_last;
        logic [NBW-1:0] h_nbits;
        exp_t           e;
        held = 1'b0;
        exp_done_next = 1'b0;
        h_dout = '0;
        h_last = 1'b0;
        h_nbits = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
                exp_done_next = 1'b0;
            end else begin
                if (exp_done_next) begin
                    check("done_after_last", W'(done), W'(1));
                    exp_done_next = 1'b0;
                end
                if (done) done_cnt++;
                if (perm_req) begin
                    perm_cnt++;
                    check("state_ready_with_perm_req", W'(state_ready), W'(1));
                end
                if (held) begin
                    check("valid_held_in_stall", W'(dout_valid), W'(1));
                    check("dout_stable", dout, h_dout);
                    check("last_stable", W'(dout_last), W'(h_last));
                    check("nbits_stable", W'(dout_nbits), W'(h_nbits));
                end
                held = 1'b0;
                if (dout_valid && dout_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_word: got %h, expected no word", dout);
                    end else begin
                        e = sb.pop_front();
                        check("dout", dout, e.data);
                        check("dout_last", W'(dout_last), W'(e.last));
                        check("dout_nbits", W'(dout_nbits), W'(e.nbits));
                        if (e.last) exp_done_next = 1'b1;
                    end
                end else if (dout_valid) begin
                    held = 1'b1;
                    h_dout = dout;
                    h_last = dout_last;
                    h_nbits = dout_nbits;
                end
            end
        end
    end

    task automatic give_block(input logic [R-1:0] blk);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!state_ready && t < 500);
        check("state_ready_wait", W'(state_ready), W'(1));
        state_in = blk;
        state_valid = 1'b1;
        @(posedge clk);
        #1;
        state_valid = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge clk);
        #1;
        out_len_bits = LW'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_req(input int len, input int seed, input int mode, input bit poke_start);
        int rem, k, nb, nblk, p0, d0, t;
        logic [R-1:0] blk;
        logic [W-1:0] word, m;
        exp_t e;
        rem = len;
        k = 0;
        while (rem > 0) begin
            nb  = (rem >= W) ? W : rem;
            blk = make_block(seed + k / NW);
            word = blk[(k % NW)*W +: W];
            m = '1;
            if (nb < W) m = (W'(1) << nb) - W'(1);
            e.data  = word & m;
            e.last  = (rem <= W);
            e.nbits = NBW'(nb);
            sb.push_back(e);
            rem -= nb;
            k++;
        end
        nblk = (len + R - 1) / R;
        ready_mode = mode;
        p0 = perm_cnt;
        d0 = done_cnt;
        pulse_start(len);
        for (int b = 0; b < nblk; b++) begin
            give_block(make_block(seed + b));
            if (poke_start && b == 0) begin
                repeat (3) @(posedge clk);
                pulse_start(8);
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        check("done_count", W'(done_cnt - d0), W'(1));
        check("words_left", W'(sb.size()), W'(0));
        check("perm_req_count", W'(perm_cnt - p0), W'(nblk - 1));
        check("busy_after_done", W'(busy), W'(0));
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_len_bits = '0;
        state_in = '0;
        state_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", W'(dout_valid), W'(0));
        check("rst_dout", dout, W'(0));
        check("rst_dout_last", W'(dout_last), W'(0));
        check("rst_dout_nbits", W'(dout_nbits), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_state_ready", W'(state_ready), W'(0));
        check("rst_perm_req", W'(perm_req), W'(0));
        check("rst_done", W'(done), W'(0));
        rst_n = 1'b1;

        run_req(256, 10, 0, 1'b0);
        run_req(100, 20, 0, 1'b0);
        run_req(1152, 30, 0, 1'b0);
        run_req(1088, 40, 0, 1'b0);
        run_req(512, 50, 1, 1'b1);

        // Zero-length request
        pulse_start(0);
        @(negedge clk);
        check("len0_done", W'(done), W'(1));
        check("len0_state_ready", W'(state_ready), W'(0));
        check("len0_busy", W'(busy), W'(0));
        @(negedge clk);
        check("len0_done_single", W'(done), W'(0));

        // Reset in the middle of EMIT
        ready_mode = 2;
        pulse_start(512);
        give_block(make_block(70));
        @(negedge clk);
        check("mid_emit_valid", W'(dout_valid), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_dout_valid", W'(dout_valid), W'(0));
        check("mid_rst_dout", dout, W'(0));
        check("mid_rst_dout_last", W'(dout_last), W'(0));
        check("mid_rst_dout_nbits", W'(dout_nbits), W'(0));
        check("mid_rst_busy", W'(busy), W'(0));
        check("mid_rst_state_ready", W'(state_ready), W'(0));
        check("mid_rst_done", W'(done), W'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_req(256, 60, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
